// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared opcodes, default widths and FSM states for the ALU sequencer
package ula_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_OPW   = 3;

    localparam logic [DEF_OPW-1:0] OP_ADD = 3'b000;
    localparam logic [DEF_OPW-1:0] OP_SUB = 3'b001;
    localparam logic [DEF_OPW-1:0] OP_AND = 3'b010;
    localparam logic [DEF_OPW-1:0] OP_OR  = 3'b011;
    localparam logic [DEF_OPW-1:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/ula_sequenciador.sv
// rtl/ula_sequenciador.sv - command-driven accumulator sequencer for the external 4-bit ALU (option: ULA_SEQ_ERR_EN)
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_err
);

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   opnd;
    logic [OPW-1:0]     opr;
    logic [WIDTH-1:0]   res_data_q;
    logic               res_zero_q;

`ifdef ULA_SEQ_ERR_EN
    logic               res_err_q;
    logic               cmd_illegal;

    assign cmd_illegal = (cmd_op > OP_XOR);
`endif

    // ALU inputs come straight from registers so the external ALU never sees cmd-port glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            acc        <= '0;
            opnd       <= '0;
            opr        <= '0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
`ifdef ULA_SEQ_ERR_EN
            res_err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        opr  <= cmd_op;
                        opnd <= cmd_data;
                        if (cmd_load) begin
                            acc        <= cmd_data;
                            res_data_q <= cmd_data;
                            res_zero_q <= (cmd_data == '0);
`ifdef ULA_SEQ_ERR_EN
                            res_err_q  <= 1'b0;
`endif
                            state      <= ST_RESP;
`ifdef ULA_SEQ_ERR_EN
                        end else if (cmd_illegal) begin
                            // rejected opcode: report current acc without touching it
                            res_data_q <= acc;
                            res_zero_q <= (acc == '0);
                            res_err_q  <= 1'b1;
                            state      <= ST_RESP;
`endif
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    acc        <= alu_z;
                    res_data_q <= alu_z;
                    res_zero_q <= (alu_z == '0);
`ifdef ULA_SEQ_ERR_EN
                    res_err_q  <= 1'b0;
`endif
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign res_valid = (state == ST_RESP);
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign alu_a     = acc;
    assign alu_b     = opnd;
    assign alu_op    = opr;

`ifdef ULA_SEQ_ERR_EN
    assign res_err   = res_err_q;
`else
    assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// tb/tb_ula_sequenciador.sv - scoreboard bench for ula_sequenciador with a behavioural ALU as alu_z source
module tb_ula_sequenciador;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_z;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_zero;
    logic       res_err;

    int         checks;
    int         errors;
    logic [3:0] acc_m;
    logic [4:0] exp_q[$];

`ifdef ULA_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    ula_sequenciador dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_z     (alu_z),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_err   (res_err)
    );

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_z = alu_fn(alu_a, alu_b, alu_op);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("res_data", int'(res_data), int'(e[3:0]));
                chk("res_zero", int'(res_zero), int'(e[3:0] == 4'd0));
                chk("res_err", int'(res_err), int'(e[4]));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    endtask

    // Expected result from the spec rules; returns the required latency
    task automatic model_accept(input logic ld, input logic [2:0] op, input logic [3:0] d, output int lat);
        logic [3:0] r;
        if (ld) begin
            acc_m = d;
            exp_q.push_back({1'b0, d});
            lat = 1;
        end else if (ERR_EN && op > 3'd4) begin
            exp_q.push_back({1'b1, acc_m});
            lat = 1;
        end else begin
            r = alu_fn(acc_m, d, op);
            acc_m = r;
            exp_q.push_back({1'b0, r});
            lat = 2;
        end
    endtask

    task automatic send(input logic ld, input logic [2:0] op, input logic [3:0] d, input bit rdy);
        int         lat;
        int         exp_lat;
        logic [3:0] a0;
        logic [3:0] held;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_data  = d;
        res_ready = rdy;
        a0 = acc_m;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_accept(ld, op, d, exp_lat);
        if (exp_lat == 2) begin
            chk("issue_alu_a", int'(alu_a), int'(a0));
            chk("issue_alu_b", int'(alu_b), int'(d));
            chk("issue_alu_op", int'(alu_op), int'(op));
        end
        lat = 1;
        while (!res_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (!rdy) begin
            held = res_data;
            repeat ($urandom_range(1, 4)) begin
                @(posedge clk); #1;
                chk("hold_valid", int'(res_valid), 1);
                chk("hold_data", int'(res_data), int'(held));
            end
            res_ready = 1'b1;
        end
    endtask

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        acc_m     = 4'd0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_zero", int'(res_zero), 0);
        chk("rst_res_err", int'(res_err), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(1'b1, 3'd0, 4'd3, 1'b1);
        send(1'b0, 3'd0, 4'd5, 1'b1);
        send(1'b0, 3'd1, 4'd8, 1'b1);
        send(1'b1, 3'd0, 4'hF, 1'b1);
        send(1'b0, 3'd0, 4'd1, 1'b1);
        send(1'b1, 3'd0, 4'd3, 1'b1);
        send(1'b0, 3'd1, 4'd5, 1'b1);

        // Backpressure with a second command held on the port
        send(1'b1, 3'd0, 4'd2, 1'b1);
        wait_ready();
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd0; cmd_data = 4'd4;
        res_ready = 1'b0;
        @(posedge clk); #1;
        model_accept(1'b0, 3'd0, 4'd4, lat);
        cmd_op = 3'd4; cmd_data = 4'd5;
        repeat (2) begin @(posedge clk); #1; end
        repeat (5) begin
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_res_data", int'(res_data), 6);
            chk("bp_cmd_ready", int'(cmd_ready), 0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after_take", int'(cmd_ready), 1);
        chk("bp_valid_after_take", int'(res_valid), 0);
        @(posedge clk); #1;
        model_accept(1'b0, 3'd4, 4'd5, lat);
        cmd_valid = 1'b0;
        chk("bp_second_taken", int'(cmd_ready), 0);

        // Illegal opcode with acc = A
        send(1'b1, 3'd0, 4'hA, 1'b1);
        send(1'b0, 3'd6, 4'd3, 1'b1);

        // Reset during ISSUE drops the in-flight command
        send(1'b1, 3'd0, 4'd7, 1'b1);
        wait_ready();
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd0; cmd_data = 4'd1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        acc_m = 4'd0;
        chk("mid_rst_alu_a", int'(alu_a), 0);
        chk("mid_rst_alu_b", int'(alu_b), 0);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_res_data", int'(res_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", int'(res_valid), 0);
        end

        repeat (40) begin
            send(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 4'($urandom), bit'($urandom_range(0, 1)));
        end

        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
